// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard scoreboard:
//   - sel_w()       width of a forward select able to encode 0..DEPTH
//   - FWD_SEL_RF    select value meaning "read the register file"
//   - sb_entry_t    one scoreboard entry {valid, addr, is_load}
// The entry address field is sized for the widest supported register number;
// narrower register numbers are zero-extended into it.
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int ENTRY_ADDR_W = 8;
    localparam int FWD_SEL_RF   = 0;

    typedef struct packed {
        logic                    valid;
        logic [ENTRY_ADDR_W-1:0] addr;
        logic                    is_load;
    } sb_entry_t;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// -----------------------------------------------------------------------------
// hazard_fwd_match
// Youngest-match search for one decode source operand against the scoreboard.
// Ports:
//   entries    in   scoreboard, entry k = instruction in stage k
//   src_addr   in   source register number
//   src_used   in   operand is actually read
//   match_sel  out  governing stage number when forwardable, else FWD_SEL_RF
//   hazard     out  governing entry is a load not yet forwardable
// -----------------------------------------------------------------------------
module hazard_fwd_match
    import hazard_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int LOAD_READY = 2,
    parameter int ADDR_W     = 5,
    localparam int SEL_W     = sel_w(DEPTH)
) (
    input  sb_entry_t [DEPTH:1] entries,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic                src_used,
    output logic [SEL_W-1:0]    match_sel,
    output logic                hazard
);

    logic             hit_s;
    logic             hit_load_s;
    logic [SEL_W-1:0] hit_sel_s;

    // Priority search: scan oldest to youngest so the lowest stage wins.
    always_comb begin
        hit_s      = 1'b0;
        hit_load_s = 1'b0;
        hit_sel_s  = SEL_W'(FWD_SEL_RF);
        for (int k = DEPTH; k >= 1; k--) begin
            if (src_used && (src_addr != {ADDR_W{1'b0}}) && entries[k].valid &&
                (entries[k].addr == ENTRY_ADDR_W'(src_addr))) begin
                hit_s      = 1'b1;
                hit_load_s = entries[k].is_load;
                hit_sel_s  = SEL_W'(k);
            end else begin
                hit_s      = hit_s;
                hit_load_s = hit_load_s;
                hit_sel_s  = hit_sel_s;
            end
        end
    end

    // Hazard flag and select; a hazardous producer is never forwarded.
    always_comb begin
        hazard    = hit_s && hit_load_s && (int'(hit_sel_s) < LOAD_READY);
        match_sel = SEL_W'(FWD_SEL_RF);
        if (hit_s && !hazard) begin
            match_sel = hit_sel_s;
        end else begin
            match_sel = SEL_W'(FWD_SEL_RF);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks destination registers of in-flight instructions, detects load-use
// hazards for the decode instruction and selects forwarding sources.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   id_valid      decode holds a valid instruction
//   id_src_addr   packed source register numbers (source s at [s*ADDR_W +: ADDR_W])
//   id_src_used   per-source "operand is read"
//   id_dst_addr   decode destination register
//   id_wen        decode instruction writes the register file
//   id_is_load    decode instruction is a load
//   flush         kill the decode instruction this cycle
//   stall         hold PC/decode, bubble into stage 1 (combinational)
//   fwd_sel       per-source forward select, 0 = register file, k = stage k
//   stall_cnt     saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_READY = 2,
    parameter int ADDR_W     = 5,
    localparam int SEL_W     = sel_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0]  id_src_addr,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [ADDR_W-1:0]          id_dst_addr,
    input  logic                       id_wen,
    input  logic                       id_is_load,
    input  logic                       flush,
    output logic                       stall,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic [31:0]                stall_cnt
);

    sb_entry_t [DEPTH:1]            entries_r;
    sb_entry_t                      new_entry_s;
    logic [NUM_SRC-1:0]             hazard_s;
    logic [NUM_SRC-1:0][SEL_W-1:0]  match_sel_s;
    logic                           stall_s;
    logic [31:0]                    stall_cnt_r;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hazard_fwd_match #(
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .ADDR_W     (ADDR_W)
        ) u_match (
            .entries    (entries_r),
            .src_addr   (id_src_addr[s*ADDR_W +: ADDR_W]),
            .src_used   (id_src_used[s]),
            .match_sel  (match_sel_s[s]),
            .hazard     (hazard_s[s])
        );
    end

    // Stall decision and forward selects; a flushed decode never stalls.
    always_comb begin
        stall_s = id_valid && !flush && (|hazard_s);
        fwd_sel = {(NUM_SRC*SEL_W){1'b0}};
        for (int s = 0; s < NUM_SRC; s++) begin
            if (stall_s) begin
                fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(FWD_SEL_RF);
            end else begin
                fwd_sel[s*SEL_W +: SEL_W] = match_sel_s[s];
            end
        end
    end

    // Entry entering stage 1: the issued decode instruction, or a bubble.
    always_comb begin
        new_entry_s = '{valid: 1'b0, addr: {ENTRY_ADDR_W{1'b0}}, is_load: 1'b0};
        if (id_valid && !stall_s && !flush) begin
            new_entry_s.valid   = id_wen && (id_dst_addr != {ADDR_W{1'b0}});
            new_entry_s.addr    = ENTRY_ADDR_W'(id_dst_addr);
            new_entry_s.is_load = id_is_load;
        end else begin
            new_entry_s.valid   = 1'b0;
        end
    end

    // Scoreboard shift register: entries age by one stage each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                entries_r[k] <= '{valid: 1'b0, addr: {ENTRY_ADDR_W{1'b0}}, is_load: 1'b0};
            end
        end else begin
            entries_r[1] <= new_entry_s;
            for (int k = 2; k <= DEPTH; k++) begin
                entries_r[k] <= entries_r[k-1];
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall     = stall_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard: one default instance (DEPTH=2,
// LOAD_READY=2) and one DEPTH=4 / LOAD_READY=3 instance sharing all inputs.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic [4:0]  id_dst_addr;
    logic        id_wen;
    logic        id_is_load;
    logic        flush;

    logic        stall;
    logic [3:0]  fwd_sel;
    logic [31:0] stall_cnt;
    logic        stall4;
    logic [5:0]  fwd_sel4;
    logic [31:0] stall_cnt4;

    int vectors     = 0;
    int miscompares = 0;

    hazard_scoreboard u_dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_used (id_src_used),
        .id_dst_addr (id_dst_addr),
        .id_wen      (id_wen),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .stall_cnt   (stall_cnt)
    );

    hazard_scoreboard #(.DEPTH(4), .LOAD_READY(3)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_used (id_src_used),
        .id_dst_addr (id_dst_addr),
        .id_wen      (id_wen),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .stall       (stall4),
        .fwd_sel     (fwd_sel4),
        .stall_cnt   (stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] used, input logic [4:0] dst,
                          input logic wen, input logic ld, input logic fl);
        id_valid    = v;
        id_src_addr = {s1, s0};
        id_src_used = used;
        id_dst_addr = dst;
        id_wen      = wen;
        id_is_load  = ld;
        flush       = fl;
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_fwd",   {28'd0, fwd_sel}, 32'd0);
        chk("reset_cnt",   stall_cnt, 32'd0);
        rst = 1'b0;

        // add $3 ; add using $3 -> forward from stage 1
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("alu_fwd_sel",   {28'd0, fwd_sel}, 32'h1);
        chk("alu_fwd_stall", {31'd0, stall}, 32'd0);

        // lw $4 ; add $4,$4 -> one stall, then both from stage 2
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 5'd4, 2'b11, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_stall1",     {31'd0, stall}, 32'd1);
        chk("lu_stall1_fwd", {28'd0, fwd_sel}, 32'd0);
        tick();
        chk("lu_stall_end",  {31'd0, stall}, 32'd0);
        chk("lu_fwd",        {28'd0, fwd_sel}, 32'hA);
        chk("lu_cnt",        stall_cnt, 32'd1);

        // $5 written twice, read -> youngest (stage 1) wins
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd5, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("youngest_fwd",   {28'd0, fwd_sel}, 32'h5);
        chk("youngest_stall", {31'd0, stall}, 32'd0);

        // lw $0 ; read $0 on both sources -> nothing matches
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("r0_fwd",   {28'd0, fwd_sel}, 32'd0);
        chk("r0_stall", {31'd0, stall}, 32'd0);

        // lw $6 ; use $6 with flush -> no stall, flushed dest $10 not tracked
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd6, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b1);
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        set_id(1'b1, 5'd6, 5'd10, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush_entry_fwd", {28'd0, fwd_sel}, 32'h2);
        chk("flush_cnt",       stall_cnt, 32'd1);

        // lw $7 ; use $7 while stalled, then reset
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_fwd",   {28'd0, fwd_sel}, 32'd0);
        chk("rst_cnt",   stall_cnt, 32'd0);
        chk("rst_cnt4",  stall_cnt4, 32'd0);
        rst = 1'b0;

        // lw $7 ; use $7 on both instances; DEPTH=4 counter near saturation
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("d4_stall1", {31'd0, stall4}, 32'd1);
        chk("d2_stall1", {31'd0, stall}, 32'd1);
        force u_dut4.stall_cnt_r = 32'hFFFF_FFFE;
        #1;
        release u_dut4.stall_cnt_r;
        tick();
        chk("d4_stall2", {31'd0, stall4}, 32'd1);
        chk("d4_cnt_max", stall_cnt4, 32'hFFFF_FFFF);
        chk("d2_stall_end", {31'd0, stall}, 32'd0);
        chk("d2_fwd", {28'd0, fwd_sel}, 32'hA);
        chk("d2_cnt", stall_cnt, 32'd1);
        tick();
        chk("d4_stall_end", {31'd0, stall4}, 32'd0);
        chk("d4_fwd", {26'd0, fwd_sel4}, 32'h1B);
        chk("d4_cnt_sat", stall_cnt4, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
